// File: rtl/calendar_countdown.sv
// Down-counting year/month/day/hour/minute/second timer. Loads a clamped value,
// then decrements once per tick while running and flags expiry at all-zero.
module calendar_countdown #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59,
    parameter int HR_MAX  = 23,
    parameter int DY_MAX  = 29,
    parameter int MNT_MAX = 11,
    parameter int YR_MAX  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_year,
    input  logic [7:0] load_month,
    input  logic [7:0] load_day,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_minute,
    input  logic [7:0] load_second,
    output logic [7:0] year,
    output logic [7:0] month,
    output logic [7:0] day,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       running,
    output logic       expired
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state;

    logic [7:0] sec_n, min_n, hr_n, dy_n, mnt_n, yr_n;
    logic       b_sec, b_min, b_hr, b_dy, b_mnt;
    logic       dec_zero, nonzero;

    function automatic logic [7:0] clamp(input logic [7:0] v, input int mx);
        return (v > 8'(mx)) ? 8'(mx) : v;
    endfunction

    // Borrow chain: each field wraps to its maximum and borrows only when it is zero
    // and every lower field is also borrowing.
    always_comb begin
        b_sec    = (second == 8'd0);
        sec_n    = b_sec ? 8'(SEC_MAX) : second - 8'd1;
        b_min    = b_sec && (minute == 8'd0);
        min_n    = !b_sec ? minute : (minute == 8'd0) ? 8'(MIN_MAX) : minute - 8'd1;
        b_hr     = b_min && (hour == 8'd0);
        hr_n     = !b_min ? hour : (hour == 8'd0) ? 8'(HR_MAX) : hour - 8'd1;
        b_dy     = b_hr && (day == 8'd0);
        dy_n     = !b_hr ? day : (day == 8'd0) ? 8'(DY_MAX) : day - 8'd1;
        b_mnt    = b_dy && (month == 8'd0);
        mnt_n    = !b_dy ? month : (month == 8'd0) ? 8'(MNT_MAX) : month - 8'd1;
        yr_n     = b_mnt ? year - 8'd1 : year;
        dec_zero = ({yr_n, mnt_n, dy_n, hr_n, min_n, sec_n} == 48'd0);
        nonzero  = ({year, month, day, hour, minute, second} != 48'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            year    <= 8'd0;
            month   <= 8'd0;
            day     <= 8'd0;
            hour    <= 8'd0;
            minute  <= 8'd0;
            second  <= 8'd0;
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
        end else if (load) begin
            year    <= clamp(load_year, YR_MAX);
            month   <= clamp(load_month, MNT_MAX);
            day     <= clamp(load_day, DY_MAX);
            hour    <= clamp(load_hour, HR_MAX);
            minute  <= clamp(load_minute, MIN_MAX);
            second  <= clamp(load_second, SEC_MAX);
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        year   <= yr_n;
                        month  <= mnt_n;
                        day    <= dy_n;
                        hour   <= hr_n;
                        minute <= min_n;
                        second <= sec_n;
                        if (dec_zero) begin
                            state   <= DONE;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end
                    end
                end
                IDLE, PAUSE: begin
                    // An all-zero value can never be started; it would underflow.
                    if (start && !stop && nonzero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calendar_countdown.sv
// Bench for calendar_countdown: a total-seconds reference model plus directed
// and randomized stimulus, compared on every falling clock edge.
module tb_calendar_countdown;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [7:0] load_year = 0, load_month = 0, load_day = 0;
    logic [7:0] load_hour = 0, load_minute = 0, load_second = 0;
    logic [7:0] year, month, day, hour, minute, second;
    logic       running, expired;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    calendar_countdown dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .load(load),
        .load_year(load_year), .load_month(load_month), .load_day(load_day),
        .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .second(second), .running(running), .expired(expired)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time as a single count of seconds.
    longint m_total = 0;
    int     m_state = 0;   // 0 idle, 1 run, 2 pause, 3 done

    function automatic longint pack(input int y, input int mo, input int d,
                                    input int h, input int mi, input int s);
        return ((((longint'(y) * 12 + mo) * 30 + d) * 24 + h) * 60 + mi) * 60 + s;
    endfunction

    function automatic logic [47:0] unpack(input longint t);
        longint r;
        logic [7:0] s, mi, h, d, mo, y;
        r = t;
        s  = 8'(r % 60); r = r / 60;
        mi = 8'(r % 60); r = r / 60;
        h  = 8'(r % 24); r = r / 24;
        d  = 8'(r % 30); r = r / 30;
        mo = 8'(r % 12); r = r / 12;
        y  = 8'(r);
        return {y, mo, d, h, mi, s};
    endfunction

    function automatic int lim(input logic [7:0] v, input int mx);
        return (int'(v) > mx) ? mx : int'(v);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_total = 0;
            m_state = 0;
        end else if (load) begin
            m_total = pack(lim(load_year, 10), lim(load_month, 11), lim(load_day, 29),
                           lim(load_hour, 23), lim(load_minute, 59), lim(load_second, 59));
            m_state = 0;
        end else if (m_state == 1) begin
            if (stop) m_state = 2;
            else if (tick) begin
                m_total = m_total - 1;
                if (m_total == 0) m_state = 3;
            end
        end else if (m_state == 0 || m_state == 2) begin
            if (start && !stop && m_total != 0) m_state = 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en)
            chk("model", {14'd0, year, month, day, hour, minute, second, running, expired},
                {14'd0, unpack(m_total), m_state == 1, m_state == 3});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] y, input logic [7:0] mo, input logic [7:0] d,
                           input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        load = 1'b1;
        load_year = y; load_month = mo; load_day = d;
        load_hour = h; load_minute = mi; load_second = s;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1; cyc(n); tick = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return {14'd0, year, month, day, hour, minute, second, running, expired};
    endfunction

    function automatic logic [63:0] lit(input int y, input int mo, input int d, input int h,
                                        input int mi, input int s, input bit r, input bit e);
        return {14'd0, 8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s), r, e};
    endfunction

    initial begin
        #2 reset = 1'b1;
        #1 chk("reset_state", outs(), lit(0, 0, 0, 0, 0, 0, 0, 0));
        cyc(2);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Basic countdown from 1:05 to zero.
        do_load(0, 0, 0, 0, 1, 5);
        chk("load_basic", outs(), lit(0, 0, 0, 0, 1, 5, 0, 0));
        do_start();
        chk("start_run", outs(), lit(0, 0, 0, 0, 1, 5, 1, 0));
        ticks(5);
        chk("five_ticks", outs(), lit(0, 0, 0, 0, 1, 0, 1, 0));
        ticks(1);
        chk("sec_borrow", outs(), lit(0, 0, 0, 0, 0, 59, 1, 0));
        ticks(58);
        chk("one_left", outs(), lit(0, 0, 0, 0, 0, 1, 1, 0));
        ticks(1);
        chk("expire", outs(), lit(0, 0, 0, 0, 0, 0, 0, 1));

        // Full borrow cascade in a single tick.
        do_load(1, 0, 0, 0, 0, 0);
        do_start();
        ticks(1);
        chk("cascade", outs(), lit(0, 11, 29, 23, 59, 59, 1, 0));

        // Clamp, then pause behaviour.
        do_load(200, 12, 30, 24, 60, 60);
        chk("clamp", outs(), lit(10, 11, 29, 23, 59, 59, 0, 0));
        do_start();
        ticks(49);
        chk("at_ten", outs(), lit(10, 11, 29, 23, 59, 10, 1, 0));
        stop = 1'b1; tick = 1'b1; start = 1'b1; cyc(1);
        stop = 1'b0; tick = 1'b0; start = 1'b0;
        chk("stop_tick", outs(), lit(10, 11, 29, 23, 59, 10, 0, 0));
        ticks(3);
        chk("pause_hold", outs(), lit(10, 11, 29, 23, 59, 10, 0, 0));
        start = 1'b1; tick = 1'b1; cyc(1); start = 1'b0; tick = 1'b0;
        chk("resume", outs(), lit(10, 11, 29, 23, 59, 10, 1, 0));
        ticks(1);
        chk("resume_tick", outs(), lit(10, 11, 29, 23, 59, 9, 1, 0));

        // Zero start ignored; DONE is sticky until load.
        do_load(0, 0, 0, 0, 0, 0);
        do_start();
        chk("zero_start", outs(), lit(0, 0, 0, 0, 0, 0, 0, 0));
        do_load(0, 0, 0, 0, 0, 2);
        do_start();
        ticks(2);
        chk("done2", outs(), lit(0, 0, 0, 0, 0, 0, 0, 1));
        start = 1'b1; tick = 1'b1; cyc(2); start = 1'b0; tick = 1'b0;
        chk("done_hold", outs(), lit(0, 0, 0, 0, 0, 0, 0, 1));
        do_load(0, 0, 0, 0, 0, 3);
        chk("reload", outs(), lit(0, 0, 0, 0, 0, 3, 0, 0));

        // Asynchronous reset between clock edges.
        do_load(0, 0, 0, 1, 0, 0);
        do_start();
        ticks(5);
        chk("pre_reset", outs(), lit(0, 0, 0, 0, 59, 55, 1, 0));
        #2 reset = 1'b1;
        #1 chk("async_reset", outs(), lit(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        cyc(1);
        do_start();
        chk("post_reset_start", outs(), lit(0, 0, 0, 0, 0, 0, 0, 0));

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            load  = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            tick  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) begin
                load_year  = 8'($urandom_range(0, 255)); load_month  = 8'($urandom_range(0, 255));
                load_day   = 8'($urandom_range(0, 255)); load_hour   = 8'($urandom_range(0, 255));
                load_minute = 8'($urandom_range(0, 255)); load_second = 8'($urandom_range(0, 255));
            end else begin
                load_year = 0; load_month = 0; load_day = 0;
                load_hour = 0;
                load_minute = 8'($urandom_range(0, 1));
                load_second = 8'($urandom_range(0, 20));
            end
            cyc(1);
        end
        load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calendar_countdown.md
Name: calendar_countdown

Overview:
- Down-counting counterpart of the team's up-counting calendar timer: loads a year/month/day/hour/minute/second value and decrements it once per enabled tick until all fields reach zero.
- Field ranges and encodings match the up-counter, so values can pass between the two blocks unchanged.
- Sits beside the timer in the clock/alarm subsystem. Used for countdown and alarm-expiry functions.

Parameters:
- SEC_MAX, 59, maximum second value
- MIN_MAX, 59, maximum minute value
- HR_MAX, 23, maximum hour value
- DY_MAX, 29, maximum day value (30-day month)
- MNT_MAX, 11, maximum month value
- YR_MAX, 10, maximum year value

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle decrement enable (1 Hz strobe)
- start  in  1  begin/resume countdown
- stop  in  1  pause countdown
- load  in  1  load strobe
- load_year, load_month, load_day, load_hour, load_minute, load_second  in  8 each  load value per field
- year, month, day, hour, minute, second  out  8 each  current remaining time, binary
- running  out  1  high while state is RUN
- expired  out  1  high in DONE

Behaviour:
- Reset (async, active-high): all six fields = 0, state = IDLE, running = 0, expired = 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Priority per clock edge: reset > load > stop > start > tick.
- load (accepted in any state):
  - Each field <= min(load_x, X_MAX). Out-of-range values clamp to the field maximum.
  - state <= IDLE, expired <= 0.
  - tick, start and stop are ignored in the load cycle.
- start:
  - Accepted in IDLE or PAUSE, and only if the value is nonzero and stop is low. Transition to RUN.
  - start while the value is all-zero: ignored, state unchanged.
  - start in RUN or DONE: no effect.
  - A tick in the same cycle as an accepted start is ignored. Counting begins with the first tick after RUN is entered.
- stop:
  - In RUN: go to PAUSE. A tick in the same cycle is ignored.
  - In other states: no effect.
  - start and stop in the same cycle: stop wins, start is dropped.
- Decrement (RUN and tick = 1), applied at the sampling edge (latency 1 cycle):
  - second != 0: second - 1.
  - Otherwise second <= SEC_MAX and borrow from minute. The same rule cascades minute -> hour -> day -> month -> year.
  - Borrow chain is combinational within one cycle; all fields update together.
  - A borrow never underflows: RUN is only held while the value is nonzero.
- Expiry:
  - If the decremented value is all zero, state <= DONE and expired <= 1 on the same edge that writes the zero value.
  - running falls on that edge.
- DONE: fields hold 0, expired holds 1, tick/start/stop ignored. Only load or reset leaves DONE.
- PAUSE and IDLE: fields hold, tick ignored.
- running = (state == RUN). expired = (state == DONE).
- Reset asserted mid-countdown: immediate clear regardless of clk. After release the block stays in IDLE until load and start.

Test Plan:
- Reset, then load 0/0/0/0/1/5 (y/mo/d/h/m/s), start, 5 ticks -> 0/0/0/0/1/0. One more tick -> second=59, minute=0. After 60 total further ticks -> all zero, expired=1, running=0 on that edge.
- Load 1/0/0/0/0/0, start, 1 tick -> 0/11/29/23/59/59 in a single cycle. Full borrow cascade verified.
- Load 200/12/30/24/60/60 -> reads 10/11/29/23/59/59 (clamped), state IDLE, running=0.
- Running with second=10: stop+tick in the same cycle -> PAUSE, second stays 10. Further ticks ignored. start -> RUN, next tick -> second=9.
- Load all-zero, start -> stays IDLE, running=0, expired=0. In DONE, apply start and tick -> no change. load 0/0/0/0/0/3 -> expired=0, IDLE.
- Assert reset asynchronously between clock edges mid-RUN -> all outputs zero before the next edge. start after release -> ignored (value zero).
